// File: rtl/reg_pipe_delay_mux_if.sv
// Bus bundle for reg_pipe_delay_mux.
// Purpose: groups the data/control inputs and the delayed outputs of the
//          selectable-latency pipeline into one interface.
// Signals:
//   ce       clock enable for the data/valid pipeline
//   clr      synchronous clear of valids and lat_err
//   x        input data (WIDTH)
//   x_vld    input data valid
//   lat      requested latency (LAT_W), 0 = combinational bypass
//   y        delayed data (WIDTH)
//   y_vld    delayed valid
//   lat_err  sticky out-of-range latency flag
// Modports: master drives inputs / observes outputs, slave is the pipeline.
interface reg_pipe_delay_mux_if #(
    parameter int WIDTH = 18,
    parameter int LAT_W = 5
);
    logic             ce;
    logic             clr;
    logic [WIDTH-1:0] x;
    logic             x_vld;
    logic [LAT_W-1:0] lat;
    logic [WIDTH-1:0] y;
    logic             y_vld;
    logic             lat_err;

    modport master (
        output ce, clr, x, x_vld, lat,
        input  y, y_vld, lat_err
    );

    modport slave (
        input  ce, clr, x, x_vld, lat,
        output y, y_vld, lat_err
    );
endinterface

// File: rtl/reg_pipe_delay_mux.sv
// reg_pipe_delay_mux
// Purpose: selectable-latency pipeline register. Latency 0 is a combinational
//          bypass; 1..DEPTH selects that many register stages. A valid bit
//          travels with the data, a latency change flushes in-flight valids,
//          and requests above DEPTH are clamped and flagged (sticky lat_err).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    reg_pipe_delay_mux_if.slave (ce, clr, x, x_vld, lat -> y, y_vld, lat_err)
// Parameters: WIDTH (data width), DEPTH (max stages, 1..16),
//             LAT_W (width of lat, 2**LAT_W > DEPTH).
// Configuration macro: PIPE_HOLD_OUT_EN -- when defined, y holds the last
//          valid output while y_vld is low (register h); otherwise y shows the
//          selected raw tap regardless of y_vld.
module reg_pipe_delay_mux #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int LAT_W = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    reg_pipe_delay_mux_if.slave bus
);

    logic [WIDTH-1:0] s_q [1:DEPTH];
    logic             v_q [1:DEPTH];
    logic [LAT_W-1:0] lat_q;
    logic             lat_err_q;

    logic             lat_over;
    logic [LAT_W-1:0] eff_lat;
    logic             flush;
    logic [WIDTH-1:0] raw_y;
    logic             out_vld;

    assign lat_over = bus.lat > LAT_W'(DEPTH);
    assign eff_lat  = lat_over ? LAT_W'(DEPTH) : bus.lat;
    // Compared against the raw request, so a change between two out-of-range
    // values also flushes.
    assign flush    = bus.lat != lat_q;

    // ---- stage registers s[1..DEPTH] / v[1..DEPTH] ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                s_q[k] <= '0;
                v_q[k] <= 1'b0;
            end
            lat_q     <= '0;
            lat_err_q <= 1'b0;
        end else begin
            lat_q <= bus.lat;
            if (bus.clr) begin
                // Data holds; only valids and the error flag are cleared.
                for (int k = 1; k <= DEPTH; k++) v_q[k] <= 1'b0;
                lat_err_q <= 1'b0;
            end else begin
                if (lat_over) lat_err_q <= 1'b1;
                if (flush) begin
                    // Shift on this edge is discarded; stale data stays but is
                    // marked invalid.
                    for (int k = 1; k <= DEPTH; k++) v_q[k] <= 1'b0;
                end else if (bus.ce) begin
                    s_q[1] <= bus.x;
                    v_q[1] <= bus.x_vld;
                    for (int k = 2; k <= DEPTH; k++) begin
                        s_q[k] <= s_q[k-1];
                        v_q[k] <= v_q[k-1];
                    end
                end
            end
        end
    end

    // ---- output tap select ----
    always_comb begin
        raw_y   = bus.x;
        out_vld = bus.x_vld;
        for (int k = 1; k <= DEPTH; k++) begin
            if (eff_lat == LAT_W'(k)) begin
                raw_y   = s_q[k];
                out_vld = v_q[k];
            end
        end
    end

    assign bus.y_vld   = out_vld;
    assign bus.lat_err = lat_err_q;

`ifdef PIPE_HOLD_OUT_EN
    logic [WIDTH-1:0] h_q;

    // ---- output hold register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
        end else if (out_vld) begin
            h_q <= raw_y;
        end
    end

    assign bus.y = out_vld ? raw_y : h_q;
`else
    assign bus.y = raw_y;
`endif

endmodule

// File: tb/tb_reg_pipe_delay_mux.sv
// Testbench for reg_pipe_delay_mux (DEPTH=4, WIDTH=18, LAT_W=5).
// Expected outputs come from a scoreboard: each accepted valid sample is pushed
// with the number of further ce-cycles before it must appear at y; flushes,
// clears and resets empty the scoreboard.
module tb_reg_pipe_delay_mux;
    localparam int WIDTH = 18;
    localparam int DEPTH = 4;
    localparam int LAT_W = 5;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } ent_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ent_t             sb [$];
    logic [LAT_W-1:0] m_lat_q;
    logic             m_err;
    logic [WIDTH-1:0] m_last;
    logic             hold_known;

    reg_pipe_delay_mux_if #(.WIDTH(WIDTH), .LAT_W(LAT_W)) bus ();

    reg_pipe_delay_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_lat_q    = '0;
        m_err      = 1'b0;
        m_last     = '0;
        hold_known = 1'b1;
    endtask

    // Drive one cycle (called just after a rising edge), check at the falling
    // edge, then advance the scoreboard across the next rising edge.
    task automatic step(input logic ce_i, input logic clr_i, input logic vld_i,
                        input logic [WIDTH-1:0] x_i, input logic [LAT_W-1:0] lat_i);
        int               li;
        int               l;
        logic             ev;
        logic [WIDTH-1:0] ed;
        bus.ce    = ce_i;
        bus.clr   = clr_i;
        bus.x_vld = vld_i;
        bus.x     = x_i;
        bus.lat   = lat_i;
        li = int'(lat_i);
        l  = (li > DEPTH) ? DEPTH : li;
        @(negedge clk);
        chk("lat_err", 32'(bus.lat_err), 32'(m_err));
        if (lat_i == m_lat_q) begin
            if (l == 0) begin
                ev = vld_i;
                ed = x_i;
            end else begin
                ev = (sb.size() > 0) && (sb[0].due == 0);
                ed = ev ? sb[0].data : '0;
            end
            chk("y_vld", 32'(bus.y_vld), 32'(ev));
            if (ev) begin
                chk("y", 32'(bus.y), 32'(ed));
                m_last     = ed;
                hold_known = 1'b1;
            end
`ifdef PIPE_HOLD_OUT_EN
            else if (hold_known) begin
                chk("y_hold", 32'(bus.y), 32'(m_last));
            end
`endif
        end else begin
            hold_known = 1'b0;
        end
        @(posedge clk);
        if (clr_i) begin
            sb.delete();
            m_err = 1'b0;
        end else begin
            if (li > DEPTH) m_err = 1'b1;
            if (lat_i != m_lat_q) begin
                sb.delete();
            end else if (ce_i) begin
                if (sb.size() > 0 && sb[0].due == 0) void'(sb.pop_front());
                for (int i = 0; i < sb.size(); i++) sb[i].due = sb[i].due - 1;
                if (l > 0 && vld_i) sb.push_back('{data: x_i, due: l - 1});
            end
        end
        m_lat_q = lat_i;
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.ce    = 1'b0;
        bus.clr   = 1'b0;
        bus.x     = '0;
        bus.x_vld = 1'b0;
        bus.lat   = LAT_W'(3);
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_y_vld", 32'(bus.y_vld), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_lat_err", 32'(bus.lat_err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: lat=3 stream 1,2,3,... (first edge is the post-reset flush)
        for (int n = 0; n <= 10; n++) step(1'b1, 1'b0, n != 0, WIDTH'(n), LAT_W'(3));

        // 2: bypass, including ce=0
        for (int n = 0; n < 8; n++) step(1'b1, 1'b0, n[0], WIDTH'($urandom), LAT_W'(0));
        for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b1, WIDTH'(50 + n), LAT_W'(0));

        // 3: steady lat=2 then switch to 4
        for (int n = 0; n < 8; n++)  step(1'b1, 1'b0, 1'b1, WIDTH'(100 + n), LAT_W'(2));
        for (int n = 0; n < 12; n++) step(1'b1, 1'b0, 1'b1, WIDTH'(200 + n), LAT_W'(4));

        // 4: ce pattern 1,0,0,1 at lat=2
        for (int n = 0; n < 6; n++)  step(1'b1, 1'b0, 1'b1, WIDTH'(300 + n), LAT_W'(2));
        for (int n = 0; n < 12; n++)
            step((n % 4 == 0) || (n % 4 == 3), 1'b0, 1'b1, WIDTH'(400 + n), LAT_W'(2));

        // 5: out-of-range latency, sticky error, clr
        for (int n = 0; n < 8; n++) step(1'b1, 1'b0, 1'b1, WIDTH'(500 + n), LAT_W'(7));
        for (int n = 0; n < 5; n++) step(1'b1, 1'b0, 1'b1, WIDTH'(600 + n), LAT_W'(2));
        step(1'b1, 1'b1, 1'b1, WIDTH'(700), LAT_W'(2));
        for (int n = 0; n < 6; n++) step(1'b1, 1'b0, n % 2 == 1, WIDTH'(800 + n), LAT_W'(2));

        // 6: asynchronous reset mid-stream
        for (int n = 0; n < 6; n++) step(1'b1, 1'b0, 1'b1, WIDTH'(900 + n), LAT_W'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_y_vld", 32'(bus.y_vld), 32'd0);
        chk("async_rst_y", 32'(bus.y), 32'd0);
        chk("async_rst_lat_err", 32'(bus.lat_err), 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 8; n++) step(1'b1, 1'b0, 1'b1, WIDTH'(1000 + n), LAT_W'(2));
        for (int n = 0; n < 6; n++) step(1'b1, 1'b0, 1'b0, WIDTH'(1100 + n), LAT_W'(2));
        step(1'b1, 1'b0, 1'b0, WIDTH'(1190), LAT_W'(0));
        step(1'b1, 1'b0, 1'b1, WIDTH'(1200), LAT_W'(0));
        step(1'b1, 1'b0, 1'b0, WIDTH'(1201), LAT_W'(0));
        step(1'b1, 1'b0, 1'b0, WIDTH'(1202), LAT_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
